rc_pulse_decoder: RTL and testbench

// Measures the servo-style high pulse from one RC receiver channel and converts it to the 8-bit

---
 rtl/rc_pulse_decoder_pkg.sv | 35 +++
 rtl/rc_pulse_decoder_divider.sv | 74 +++++++
 rtl/rc_pulse_decoder.sv | 147 ++++++++++++++
 tb/tb_rc_pulse_decoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rc_pulse_decoder_pkg.sv
// Shared types, default timing constants and arithmetic helpers for the RC pulse decoder.
package rc_pulse_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DIVIDE  = 2'd2
    } state_t;

    localparam int unsigned DEF_US_DIV        = 50;
    localparam int unsigned DEF_MIN_US        = 1000;
    localparam int unsigned DEF_MAX_US        = 2000;
    localparam int unsigned DEF_GLITCH_US     = 500;
    localparam int unsigned DEF_ABORT_US      = 2500;
    localparam int unsigned DEF_TIMEOUT_US    = 50000;
    localparam int unsigned DEF_FAILSAFE_DUTY = 128;
    localparam int unsigned DIV_STEPS         = 24;

    function automatic logic [15:0] clamp_width(input logic [15:0] w,
                                                input logic [15:0] lo,
                                                input logic [15:0] hi);
        if (w < lo) begin
            return lo;
        end else if (w > hi) begin
            return hi;
        end else begin
            return w;
        end
    endfunction

    function automatic logic [23:0] scale_num(input logic [15:0] w, input logic [15:0] lo);
        return 24'(w - lo) * 24'd255;
    endfunction

endpackage

// File: rtl/rc_pulse_decoder_divider.sv
// 24-step restoring divider: 24b dividend / 16b divisor, start accepted only while idle.
module serial_divider
    import rc_pulse_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [23:0] quotient,
    output logic [15:0] remainder
);

    logic        busy_r;
    logic        done_r;
    logic [4:0]  step_r;
    logic [23:0] quo_r;
    logic [15:0] rem_r;
    logic [15:0] dsr_r;
    logic [16:0] trial_s;
    logic        ge_s;
    logic [15:0] next_rem_s;

    // One restoring step: shift in the next dividend bit and subtract if it fits.
    always_comb begin
        trial_s = {rem_r, quo_r[23]};
        ge_s    = (trial_s >= {1'b0, dsr_r});
        if (ge_s) begin
            next_rem_s = 16'(trial_s - {1'b0, dsr_r});
        end else begin
            next_rem_s = trial_s[15:0];
        end
    end

    // Load operands on start, then iterate DIV_STEPS times and pulse done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            step_r <= 5'd0;
            quo_r  <= 24'd0;
            rem_r  <= 16'd0;
            dsr_r  <= 16'd0;
        end else begin
            done_r <= 1'b0;
            if (!busy_r) begin
                if (start) begin
                    busy_r <= 1'b1;
                    step_r <= 5'd0;
                    quo_r  <= dividend;
                    rem_r  <= 16'd0;
                    dsr_r  <= divisor;
                end
            end else begin
                rem_r <= next_rem_s;
                quo_r <= {quo_r[22:0], ge_s};
                if (step_r == 5'(DIV_STEPS - 1)) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end else begin
                    step_r <= step_r + 5'd1;
                end
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/rc_pulse_decoder.sv
// Measures one RC servo pulse, maps MIN_US..MAX_US to duty 0..255, holds it between
// frames and falls back to FAILSAFE_DUTY when valid pulses stop arriving.
module rc_pulse_decoder
    import rc_pulse_decoder_pkg::*;
#(
    parameter int unsigned US_DIV        = DEF_US_DIV,
    parameter int unsigned MIN_US        = DEF_MIN_US,
    parameter int unsigned MAX_US        = DEF_MAX_US,
    parameter int unsigned GLITCH_US     = DEF_GLITCH_US,
    parameter int unsigned ABORT_US      = DEF_ABORT_US,
    parameter int unsigned TIMEOUT_US    = DEF_TIMEOUT_US,
    parameter int unsigned FAILSAFE_DUTY = DEF_FAILSAFE_DUTY
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       rc_pulse_in,
    output logic [7:0] duty_cycle_out,
    output logic       duty_valid_out,
    output logic       failsafe_out
);

    state_t      state_r;
    logic        sync1_r, sync2_r, prev_r;
    logic [15:0] presc_r;
    logic [15:0] width_cnt_r;
    logic [16:0] to_cnt_r;
    logic [7:0]  duty_r;
    logic        valid_r;
    logic        failsafe_r;

    logic        rise_s, fall_s, tick_s;
    logic        div_start_s, div_busy_s, div_done_s, div_fault_s;
    logic [23:0] div_num_s, div_quo_s;
    logic [15:0] div_den_s, div_rem_s, width_clamped_s;

    assign rise_s          = sync2_r & ~prev_r;
    assign fall_s          = ~sync2_r & prev_r;
    assign tick_s          = (presc_r == 16'(US_DIV - 1));
    assign width_clamped_s = clamp_width(width_cnt_r, 16'(MIN_US), 16'(MAX_US));
    assign div_num_s       = scale_num(width_clamped_s, 16'(MIN_US));
    assign div_den_s       = 16'(MAX_US - MIN_US);
    // A result that cannot come from a healthy divider is dropped rather than displayed.
    assign div_fault_s     = (|div_quo_s[23:8]) || (div_rem_s >= div_den_s);

    // Input synchronizer and edge history; all held high in reset so a stuck-high line is no edge.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= rc_pulse_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Free-running microsecond prescaler.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            presc_r <= 16'd0;
        end else if (tick_s) begin
            presc_r <= 16'd0;
        end else begin
            presc_r <= presc_r + 16'd1;
        end
    end

    // Divider start request: accepted falling edge inside the glitch/abort window.
    always_comb begin
        div_start_s = 1'b0;
        if ((state_r == ST_MEASURE) && fall_s && !div_busy_s &&
            (width_cnt_r >= 16'(GLITCH_US)) && (width_cnt_r < 16'(ABORT_US))) begin
            div_start_s = 1'b1;
        end else begin
            div_start_s = 1'b0;
        end
    end

    serial_divider u_div (
        .clk       (clk_in),
        .rst       (reset_in),
        .start     (div_start_s),
        .dividend  (div_num_s),
        .divisor   (div_den_s),
        .busy      (div_busy_s),
        .done      (div_done_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Measurement FSM, timeout counter and registered outputs.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_r     <= ST_IDLE;
            width_cnt_r <= 16'd0;
            to_cnt_r    <= 17'd0;
            duty_r      <= 8'(FAILSAFE_DUTY);
            valid_r     <= 1'b0;
            failsafe_r  <= 1'b1;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        width_cnt_r <= 16'd0;
                        state_r     <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (width_cnt_r >= 16'(ABORT_US)) begin
                        state_r <= ST_IDLE;
                    end else if (fall_s) begin
                        state_r <= div_start_s ? ST_DIVIDE : ST_IDLE;
                    end else if (tick_s && sync2_r) begin
                        width_cnt_r <= width_cnt_r + 16'd1;
                    end
                end
                ST_DIVIDE: begin
                    if (div_done_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase

            // A completed update outranks a timeout landing on the same cycle.
            if ((state_r == ST_DIVIDE) && div_done_s && !div_fault_s) begin
                duty_r     <= div_quo_s[7:0];
                valid_r    <= 1'b1;
                failsafe_r <= 1'b0;
                to_cnt_r   <= 17'd0;
            end else if (tick_s && (to_cnt_r < 17'(TIMEOUT_US))) begin
                to_cnt_r <= to_cnt_r + 17'd1;
                if (to_cnt_r == 17'(TIMEOUT_US - 1)) begin
                    duty_r     <= 8'(FAILSAFE_DUTY);
                    failsafe_r <= 1'b1;
                end
            end
        end
    end

    assign duty_cycle_out = duty_r;
    assign duty_valid_out = valid_r;
    assign failsafe_out   = failsafe_r;

endmodule

// File: tb/tb_rc_pulse_decoder.sv
// Randomized self-checking bench for rc_pulse_decoder using scaled-down timing so the
// timeout path fits in a short run; expectations come from the width-to-duty rules.
module tb_rc_pulse_decoder;

    localparam int D      = 4;
    localparam int MIN    = 100;
    localparam int MAX    = 200;
    localparam int GLITCH = 50;
    localparam int ABORT  = 250;
    localparam int TMO    = 1000;
    localparam int FS     = 128;
    localparam int LAT    = 28;
    localparam int T6_W   = 230;
    localparam int T6_RISE = TMO * D - LAT - T6_W * D;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       rc_pulse_in;
    logic [7:0] duty_cycle_out;
    logic       duty_valid_out;
    logic       failsafe_out;

    int n_checks   = 0;
    int n_fail     = 0;
    int strobe_cnt = 0;
    int last_w     = 0;
    bit model_fs   = 1'b1;
    int t2_w[4]    = '{100, 200, 230, 90};

    always #5 clk_in = ~clk_in;

    rc_pulse_decoder #(
        .US_DIV(D), .MIN_US(MIN), .MAX_US(MAX), .GLITCH_US(GLITCH),
        .ABORT_US(ABORT), .TIMEOUT_US(TMO), .FAILSAFE_DUTY(FS)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .rc_pulse_in    (rc_pulse_in),
        .duty_cycle_out (duty_cycle_out),
        .duty_valid_out (duty_valid_out),
        .failsafe_out   (failsafe_out)
    );

    always @(negedge clk_in) begin
        if (duty_valid_out) strobe_cnt <= strobe_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_duty(input int w);
        if (w <= MIN) return 0;
        if (w >= MAX) return 255;
        return (w - MIN) * 255 / (MAX - MIN);
    endfunction

    // Width is resolved to one microsecond, so a neighbouring width's duty is also acceptable.
    task automatic check_width(input string tag, input int obs, input int w);
        int e;
        e = model_duty(w);
        if (obs == model_duty(w - 1) || obs == model_duty(w + 1)) e = obs;
        check(tag, obs, e);
    endtask

    task automatic idle_us(input int us);
        repeat (us * D) @(negedge clk_in);
    endtask

    task automatic do_reset(input string tag);
        reset_in    = 1'b1;
        rc_pulse_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check({tag, "_rst_duty"}, duty_cycle_out, FS);
        check({tag, "_rst_valid"}, duty_valid_out, 0);
        check({tag, "_rst_fs"}, failsafe_out, 1);
        reset_in = 1'b0;
        model_fs = 1'b1;
    endtask

    task automatic send_pulse(input int w);
        @(posedge clk_in);
        #($urandom_range(1, 9));
        rc_pulse_in = 1'b1;
        #(w * D * 10);
        rc_pulse_in = 1'b0;
    endtask

    task automatic pulse_expect(input string tag, input int w, input bit accept);
        int s0;
        s0 = strobe_cnt;
        send_pulse(w);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (strobe_cnt != s0) break;
        end
        repeat (5) @(negedge clk_in);
        if (accept) begin
            check({tag, "_strobes"}, strobe_cnt - s0, 1);
            check_width({tag, "_duty"}, duty_cycle_out, w);
            check({tag, "_fs"}, failsafe_out, 0);
            last_w   = w;
            model_fs = 1'b0;
        end else begin
            check({tag, "_strobes"}, strobe_cnt - s0, 0);
            if (model_fs) check({tag, "_duty"}, duty_cycle_out, FS);
            else          check_width({tag, "_duty"}, duty_cycle_out, last_w);
            check({tag, "_fs"}, failsafe_out, int'(model_fs));
        end
        idle_us($urandom_range(10, 40));
    endtask

    task automatic latency_pulse(input int w);
        int n;
        bit seen;
        @(negedge clk_in);
        rc_pulse_in = 1'b1;
        repeat (w * D) @(negedge clk_in);
        rc_pulse_in = 1'b0;
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in);
            n++;
            @(negedge clk_in);
            if (duty_valid_out) begin
                seen = 1'b1;
                break;
            end
        end
        check("t2_latency", seen ? n : -1, LAT);
        check_width("t2_duty", duty_cycle_out, w);
        last_w   = w;
        model_fs = 1'b0;
        idle_us(20);
    endtask

    initial begin
        int s0;
        int kind;
        int w;
        bit prev_rej;

        do_reset("t1");
        idle_us(5);
        check("t1_fs_before", failsafe_out, 1);
        pulse_expect("t1", 150, 1'b1);

        foreach (t2_w[i]) latency_pulse(t2_w[i]);

        pulse_expect("t3_glitch", 30, 1'b0);
        pulse_expect("t3_abort", 300, 1'b0);
        pulse_expect("t3_after", 125, 1'b1);

        pulse_expect("t4_valid", 175, 1'b1);
        repeat (TMO * D - 200) @(negedge clk_in);
        check("t4_fs_early", failsafe_out, 0);
        s0 = strobe_cnt;
        repeat (300) @(negedge clk_in);
        check("t4_to_duty", duty_cycle_out, FS);
        check("t4_to_fs", failsafe_out, 1);
        check("t4_to_strobes", strobe_cnt - s0, 0);
        model_fs = 1'b1;
        pulse_expect("t4_recover", 150, 1'b1);

        send_pulse(150);
        rc_pulse_in = 1'b1;
        idle_us(60);
        reset_in = 1'b1;
        repeat (3) @(negedge clk_in);
        check("t5_rst_duty", duty_cycle_out, FS);
        check("t5_rst_valid", duty_valid_out, 0);
        check("t5_rst_fs", failsafe_out, 1);
        reset_in = 1'b0;
        model_fs = 1'b1;
        s0 = strobe_cnt;
        idle_us(100);
        rc_pulse_in = 1'b0;
        repeat (60) @(negedge clk_in);
        check("t5_no_strobe", strobe_cnt - s0, 0);
        check("t5_hold_duty", duty_cycle_out, FS);
        check("t5_hold_fs", failsafe_out, 1);
        pulse_expect("t5_next", 160, 1'b1);

        do_reset("t6");
        repeat (T6_RISE) @(posedge clk_in);
        @(negedge clk_in);
        rc_pulse_in = 1'b1;
        repeat (T6_W * D) @(posedge clk_in);
        @(negedge clk_in);
        rc_pulse_in = 1'b0;
        repeat (LAT) @(posedge clk_in);
        @(negedge clk_in);
        check("t6_valid", duty_valid_out, 1);
        check("t6_duty", duty_cycle_out, 255);
        check("t6_fs", failsafe_out, 0);
        check("t6_to_cnt", int'(dut.to_cnt_r), 0);
        last_w   = T6_W;
        model_fs = 1'b0;
        idle_us(20);

        prev_rej = 1'b0;
        for (int i = 0; i < 24; i++) begin
            kind = prev_rej ? 0 : int'($urandom_range(0, 9));
            if (kind < 7) begin
                w = int'($urandom_range(GLITCH + 2, ABORT - 2));
                pulse_expect("rnd_valid", w, 1'b1);
                prev_rej = 1'b0;
            end else if (kind < 9) begin
                w = int'($urandom_range(3, GLITCH - 2));
                pulse_expect("rnd_glitch", w, 1'b0);
                prev_rej = 1'b1;
            end else begin
                w = int'($urandom_range(ABORT + 2, ABORT + 20));
                pulse_expect("rnd_abort", w, 1'b0);
                prev_rej = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
